// File: rtl/axi_lite_sim_console.sv
// AXI4-Lite simulation console: byte TX FIFO, sticky exit register, scratch register
// and free-running cycle counter in a 256-byte window at BASE.
module axi_lite_sim_console #(
  parameter logic [31:0] BASE    = 32'h2000_0000,
  parameter int unsigned FIFO_DP = 16
) (
  input  logic        CLK,
  input  logic        RSTn,
  input  logic [31:0] CONSOLE_AWADDR,
  input  logic        CONSOLE_AWVALID,
  output logic        CONSOLE_AWREADY,
  input  logic [63:0] CONSOLE_WDATA,
  input  logic [7:0]  CONSOLE_WSTRB,
  input  logic        CONSOLE_WVALID,
  output logic        CONSOLE_WREADY,
  output logic [1:0]  CONSOLE_BRESP,
  output logic        CONSOLE_BVALID,
  input  logic        CONSOLE_BREADY,
  input  logic [31:0] CONSOLE_ARADDR,
  input  logic        CONSOLE_ARVALID,
  output logic        CONSOLE_ARREADY,
  output logic [63:0] CONSOLE_RDATA,
  output logic [1:0]  CONSOLE_RRESP,
  output logic        CONSOLE_RVALID,
  input  logic        CONSOLE_RREADY,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        exit_valid,
  output logic [63:0] exit_code
);

  localparam int unsigned PW = (FIFO_DP > 1) ? $clog2(FIFO_DP) : 1;
  localparam int unsigned CW = PW + 1;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [4:0] {
    REG_TX      = 5'h00,
    REG_STATUS  = 5'h01,
    REG_EXIT    = 5'h02,
    REG_SCRATCH = 5'h03,
    REG_CYCLE   = 5'h04
  } reg_sel_e;

  logic        live;
  logic        aw_held, w_held;
  logic [31:0] aw_addr_q;
  logic [63:0] w_data_q;
  logic [7:0]  w_strb_q;
  logic        bvalid_q, rvalid_q;
  logic [1:0]  bresp_q, rresp_q;
  logic [63:0] rdata_q;
  logic [7:0]  mem [FIFO_DP];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic        full, empty, push, pop;
  logic        exit_valid_q;
  logic [63:0] exit_code_q, scratch_q, cycle_q;
  logic        aw_hs, w_hs, b_hs, ar_hs, r_hs, wr_fire;
  logic [31:0] aw_off, ar_off;
  logic [63:0] wmask, status, rd_data;
  logic [1:0]  wr_resp, rd_resp;
  logic        exit_we, scratch_we;
  logic        unused_ok;

  // live holds the READY outputs low until the first clock after reset release
  assign CONSOLE_AWREADY = live & ~aw_held;
  assign CONSOLE_WREADY  = live & ~w_held;
  assign CONSOLE_ARREADY = live & ~rvalid_q;
  assign CONSOLE_BVALID  = bvalid_q;
  assign CONSOLE_BRESP   = bresp_q;
  assign CONSOLE_RVALID  = rvalid_q;
  assign CONSOLE_RRESP   = rresp_q;
  assign CONSOLE_RDATA   = rdata_q;
  assign exit_valid      = exit_valid_q;
  assign exit_code       = exit_code_q;

  assign aw_hs   = CONSOLE_AWVALID & CONSOLE_AWREADY;
  assign w_hs    = CONSOLE_WVALID & CONSOLE_WREADY;
  assign b_hs    = bvalid_q & CONSOLE_BREADY;
  assign ar_hs   = CONSOLE_ARVALID & CONSOLE_ARREADY;
  assign r_hs    = rvalid_q & CONSOLE_RREADY;
  assign wr_fire = aw_held & w_held & ~bvalid_q;

  assign aw_off    = aw_addr_q - BASE;
  assign ar_off    = CONSOLE_ARADDR - BASE;
  assign unused_ok = ^{aw_off[2:0], ar_off[2:0]};

  assign empty    = (count == '0);
  assign full     = (count == CW'(FIFO_DP));
  assign pop      = ~empty & tx_ready;
  assign tx_valid = ~empty;
  assign tx_data  = empty ? '0 : mem[rd_ptr];
  assign status   = {54'd0, full, empty, 8'(count)};

  always_comb begin
    wmask = '0;
    for (int unsigned i = 0; i < 8; i++) wmask[i*8 +: 8] = {8{w_strb_q[i]}};
  end

  // A pop in the same cycle frees a slot, so a push into a full FIFO still succeeds
  always_comb begin
    wr_resp    = RESP_OKAY;
    push       = 1'b0;
    exit_we    = 1'b0;
    scratch_we = 1'b0;
    if (aw_off[31:8] != '0) begin
      wr_resp = RESP_SLVERR;
    end else begin
      case (aw_off[7:3])
        REG_TX: begin
          if (w_strb_q[0]) begin
            if (!full || pop) push = wr_fire;
            else              wr_resp = RESP_SLVERR;
          end
        end
        REG_STATUS, REG_CYCLE: ;
        REG_EXIT:    exit_we    = wr_fire & ~exit_valid_q;
        REG_SCRATCH: scratch_we = wr_fire;
        default:     wr_resp    = RESP_SLVERR;
      endcase
    end
  end

  always_comb begin
    rd_data = '0;
    rd_resp = RESP_OKAY;
    if (ar_off[31:8] != '0) begin
      rd_resp = RESP_SLVERR;
    end else begin
      case (ar_off[7:3])
        REG_STATUS:      rd_data = status;
        REG_SCRATCH:     rd_data = scratch_q;
        REG_CYCLE:       rd_data = cycle_q;
        REG_TX, REG_EXIT: ;
        default:         rd_resp = RESP_SLVERR;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      live      <= 1'b0;
      aw_held   <= 1'b0;
      w_held    <= 1'b0;
      aw_addr_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= '0;
    end else begin
      live <= 1'b1;
      if (aw_hs) begin
        aw_held   <= 1'b1;
        aw_addr_q <= CONSOLE_AWADDR;
      end else if (b_hs) begin
        aw_held <= 1'b0;
      end
      if (w_hs) begin
        w_held   <= 1'b1;
        w_data_q <= CONSOLE_WDATA;
        w_strb_q <= CONSOLE_WSTRB;
      end else if (b_hs) begin
        w_held <= 1'b0;
      end
      if (wr_fire) begin
        bvalid_q <= 1'b1;
        bresp_q  <= wr_resp;
      end else if (b_hs) begin
        bvalid_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr] <= w_data_q[7:0];
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      exit_valid_q <= 1'b0;
      exit_code_q  <= '0;
      scratch_q    <= '0;
      cycle_q      <= '0;
    end else begin
      cycle_q <= cycle_q + 64'd1;
      if (exit_we) begin
        exit_valid_q <= 1'b1;
        exit_code_q  <= w_data_q & wmask;
      end
      if (scratch_we) scratch_q <= (scratch_q & ~wmask) | (w_data_q & wmask);
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      rvalid_q <= 1'b0;
      rresp_q  <= '0;
      rdata_q  <= '0;
    end else if (ar_hs) begin
      rvalid_q <= 1'b1;
      rresp_q  <= rd_resp;
      rdata_q  <= rd_data;
    end else if (r_hs) begin
      rvalid_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_axi_lite_sim_console.sv
// Scoreboard bench for axi_lite_sim_console: expected B/R responses are queued when a
// request is issued and compared when the response arrives; a byte queue models the TX FIFO.
module tb_axi_lite_sim_console;

  localparam logic [31:0] BASE   = 32'h2000_0000;
  localparam logic [1:0]  OKAY   = 2'b00;
  localparam logic [1:0]  SLVERR = 2'b10;

  logic        CLK = 1'b0;
  logic        RSTn = 1'b0;
  logic [31:0] CONSOLE_AWADDR = '0;
  logic        CONSOLE_AWVALID = 1'b0;
  logic        CONSOLE_AWREADY;
  logic [63:0] CONSOLE_WDATA = '0;
  logic [7:0]  CONSOLE_WSTRB = '0;
  logic        CONSOLE_WVALID = 1'b0;
  logic        CONSOLE_WREADY;
  logic [1:0]  CONSOLE_BRESP;
  logic        CONSOLE_BVALID;
  logic        CONSOLE_BREADY = 1'b0;
  logic [31:0] CONSOLE_ARADDR = '0;
  logic        CONSOLE_ARVALID = 1'b0;
  logic        CONSOLE_ARREADY;
  logic [63:0] CONSOLE_RDATA;
  logic [1:0]  CONSOLE_RRESP;
  logic        CONSOLE_RVALID;
  logic        CONSOLE_RREADY = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic        exit_valid;
  logic [63:0] exit_code;

  typedef struct {
    logic [63:0] d;
    logic [1:0]  r;
    bit          chk;
  } rexp_t;

  logic [1:0] exp_b[$];
  rexp_t      exp_r[$];
  logic [7:0] fifo_q[$];

  int n_checks = 0;
  int n_errors = 0;

  axi_lite_sim_console #(.BASE(BASE), .FIFO_DP(16)) dut (
    .CLK(CLK), .RSTn(RSTn),
    .CONSOLE_AWADDR(CONSOLE_AWADDR), .CONSOLE_AWVALID(CONSOLE_AWVALID),
    .CONSOLE_AWREADY(CONSOLE_AWREADY),
    .CONSOLE_WDATA(CONSOLE_WDATA), .CONSOLE_WSTRB(CONSOLE_WSTRB),
    .CONSOLE_WVALID(CONSOLE_WVALID), .CONSOLE_WREADY(CONSOLE_WREADY),
    .CONSOLE_BRESP(CONSOLE_BRESP), .CONSOLE_BVALID(CONSOLE_BVALID),
    .CONSOLE_BREADY(CONSOLE_BREADY),
    .CONSOLE_ARADDR(CONSOLE_ARADDR), .CONSOLE_ARVALID(CONSOLE_ARVALID),
    .CONSOLE_ARREADY(CONSOLE_ARREADY),
    .CONSOLE_RDATA(CONSOLE_RDATA), .CONSOLE_RRESP(CONSOLE_RRESP),
    .CONSOLE_RVALID(CONSOLE_RVALID), .CONSOLE_RREADY(CONSOLE_RREADY),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .exit_valid(exit_valid), .exit_code(exit_code)
  );

  always #5 CLK = ~CLK;

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] status_model();
    int n = fifo_q.size();
    return {54'd0, n == 16, n == 0, 8'(n)};
  endfunction

  task automatic do_aw(input logic [31:0] a);
    bit hs = 0;
    CONSOLE_AWADDR  = a;
    CONSOLE_AWVALID = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge CLK);
      if (CONSOLE_AWREADY) begin hs = 1; break; end
    end
    if (hs) @(posedge CLK);
    else    check("aw_timeout", CONSOLE_AWREADY, 1);
    #1 CONSOLE_AWVALID = 1'b0;
  endtask

  task automatic do_w(input logic [63:0] d, input logic [7:0] s);
    bit hs = 0;
    CONSOLE_WDATA  = d;
    CONSOLE_WSTRB  = s;
    CONSOLE_WVALID = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge CLK);
      if (CONSOLE_WREADY) begin hs = 1; break; end
    end
    if (hs) @(posedge CLK);
    else    check("w_timeout", CONSOLE_WREADY, 1);
    #1 CONSOLE_WVALID = 1'b0;
  endtask

  task automatic wait_b(input string tag);
    bit got = 0;
    CONSOLE_BREADY = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge CLK);
      if (CONSOLE_BVALID) begin got = 1; break; end
    end
    if (got) begin
      check({tag, "_bresp"}, CONSOLE_BRESP, exp_b.pop_front());
      @(posedge CLK);
    end else begin
      check({tag, "_b_timeout"}, CONSOLE_BVALID, 1);
      void'(exp_b.pop_front());
    end
    #1 CONSOLE_BREADY = 1'b0;
  endtask

  // w_lead > 0: W leads AW by w_lead cycles; < 0: AW leads W; 0: both together
  task automatic axi_write(input string tag, input logic [31:0] a, input logic [63:0] d,
                           input logic [7:0] s, input logic [1:0] exp, input int w_lead);
    exp_b.push_back(exp);
    if (w_lead > 0) begin
      do_w(d, s);
      repeat (w_lead - 1) @(posedge CLK);
      #1 do_aw(a);
    end else if (w_lead < 0) begin
      do_aw(a);
      repeat (-w_lead - 1) @(posedge CLK);
      #1 do_w(d, s);
    end else begin
      fork
        do_aw(a);
        do_w(d, s);
      join
    end
    wait_b(tag);
  endtask

  task automatic axi_read(input string tag, input logic [31:0] a, input logic [63:0] ed,
                          input logic [1:0] er, input bit chk,
                          output logic [63:0] got, output int lat);
    rexp_t e;
    bit hs = 0;
    got = '0;
    lat = 0;
    e.d = ed; e.r = er; e.chk = chk;
    exp_r.push_back(e);
    CONSOLE_ARADDR  = a;
    CONSOLE_ARVALID = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge CLK);
      if (CONSOLE_ARREADY) begin hs = 1; break; end
    end
    if (!hs) begin
      check({tag, "_ar_timeout"}, CONSOLE_ARREADY, 1);
      void'(exp_r.pop_front());
      CONSOLE_ARVALID = 1'b0;
      return;
    end
    @(posedge CLK);
    #1 CONSOLE_ARVALID = 1'b0;
    CONSOLE_RREADY = 1'b1;
    for (int i = 1; i <= 100; i++) begin
      @(negedge CLK);
      if (CONSOLE_RVALID) begin lat = i; break; end
    end
    if (lat == 0) begin
      check({tag, "_r_timeout"}, CONSOLE_RVALID, 1);
      void'(exp_r.pop_front());
    end else begin
      e = exp_r.pop_front();
      got = CONSOLE_RDATA;
      check({tag, "_rresp"}, CONSOLE_RRESP, e.r);
      if (e.chk) check({tag, "_rdata"}, CONSOLE_RDATA, e.d);
      @(posedge CLK);
    end
    #1 CONSOLE_RREADY = 1'b0;
  endtask

  task automatic tx_byte(input string tag, input logic [7:0] b);
    logic [1:0] r = (fifo_q.size() < 16) ? OKAY : SLVERR;
    if (r == OKAY) fifo_q.push_back(b);
    axi_write(tag, BASE, {56'h0, b}, 8'h01, r, 0);
  endtask

  task automatic drain();
    tx_ready = 1'b1;
    for (int i = 0; i < 64; i++) begin
      @(negedge CLK);
      if (fifo_q.size() == 0) break;
      check("drain_valid", tx_valid, 1);
      check("drain_data", tx_data, fifo_q.pop_front());
    end
    tx_ready = 1'b0;
    check("drain_empty", tx_valid, 0);
    @(posedge CLK);
    #1;
  endtask

  initial begin
    logic [63:0] rd, c1, c2;
    int lat;

    // reset
    repeat (3) @(posedge CLK);
    #1;
    check("rst_awready", CONSOLE_AWREADY, 0);
    check("rst_wready", CONSOLE_WREADY, 0);
    check("rst_arready", CONSOLE_ARREADY, 0);
    check("rst_bvalid", CONSOLE_BVALID, 0);
    check("rst_rvalid", CONSOLE_RVALID, 0);
    check("rst_rdata", CONSOLE_RDATA, 0);
    check("rst_tx", {tx_valid, tx_data}, 0);
    check("rst_exit", {exit_valid, exit_code}, 0);
    RSTn = 1'b1;
    @(negedge CLK);
    check("rel_awready_early", CONSOLE_AWREADY, 0);
    @(negedge CLK);
    check("rel_readies", {CONSOLE_AWREADY, CONSOLE_WREADY, CONSOLE_ARREADY}, 3'b111);
    @(posedge CLK);
    #1;

    // STATUS after reset, one-cycle read latency
    axi_read("status_rst", BASE + 32'h08, 64'h100, OKAY, 1, rd, lat);
    check("rd_latency", lat, 1);

    // single TX byte, W leading AW by three cycles
    fifo_q.push_back(8'h41);
    axi_write("tx41", BASE, 64'h41, 8'h01, OKAY, 3);
    check("tx41_valid", tx_valid, 1);
    check("tx41_data", tx_data, fifo_q[0]);
    axi_read("status_1", BASE + 32'h08, status_model(), OKAY, 1, rd, lat);
    drain();

    // fill to 16, 17th dropped with SLVERR
    for (int i = 0; i < 17; i++) tx_byte("fill", 8'h60 + 8'(i));
    axi_read("status_full", BASE + 32'h08, 64'h210, OKAY, 1, rd, lat);

    // full FIFO: pop and push in the same cycle
    exp_b.push_back(OKAY);
    fork
      do_aw(BASE);
      do_w(64'hA5, 8'h01);
    join
    tx_ready = 1'b1;
    @(negedge CLK);
    check("pp_valid", tx_valid, 1);
    check("pp_head", tx_data, fifo_q.pop_front());
    @(posedge CLK);
    #1 tx_ready = 1'b0;
    fifo_q.push_back(8'hA5);
    wait_b("pushpop");
    axi_read("status_pp", BASE + 32'h08, 64'h210, OKAY, 1, rd, lat);

    // strobe without byte 0 pushes nothing, even when full
    axi_write("tx_nostrb", BASE, 64'hEE00, 8'h02, OKAY, 0);
    axi_read("status_ns", BASE + 32'h08, status_model(), OKAY, 1, rd, lat);
    drain();
    axi_read("status_empty", BASE + 32'h08, 64'h100, OKAY, 1, rd, lat);

    // EXIT is sticky on the first write
    axi_write("exit1", BASE + 32'h10, 64'h1, 8'hFF, OKAY, 0);
    check("exit1_valid", exit_valid, 1);
    check("exit1_code", exit_code, 64'h1);
    axi_write("exit3", BASE + 32'h10, 64'h3, 8'hFF, OKAY, -2);
    check("exit3_valid", exit_valid, 1);
    check("exit3_code", exit_code, 64'h1);

    // decode errors and W-only / R-only accesses
    axi_read("rd_oob", BASE + 32'h100, 64'h0, SLVERR, 1, rd, lat);
    axi_read("rd_below", BASE - 32'h8, 64'h0, SLVERR, 1, rd, lat);
    axi_read("rd_unlisted", BASE + 32'h28, 64'h0, SLVERR, 1, rd, lat);
    axi_read("rd_tx", BASE + 32'h00, 64'h0, OKAY, 1, rd, lat);
    axi_write("wr_unlisted", BASE + 32'h28, 64'h5, 8'hFF, SLVERR, 0);
    axi_write("wr_oob", BASE + 32'h100, 64'h5, 8'hFF, SLVERR, 0);
    axi_write("wr_status", BASE + 32'h08, 64'h5, 8'hFF, OKAY, 0);

    // SCRATCH byte masking
    axi_write("scr_wr", BASE + 32'h18, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F, OKAY, -2);
    axi_read("scr_rd", BASE + 32'h1C, 64'h0000_0000_FFFF_FFFF, OKAY, 1, rd, lat);
    axi_write("scr_wr2", BASE + 32'h18, 64'h1234_5678_0000_0000, 8'hC0, OKAY, 0);
    axi_read("scr_rd2", BASE + 32'h18, 64'h1234_0000_FFFF_FFFF, OKAY, 1, rd, lat);

    // CYCLE reads with AR handshakes ten clocks apart
    axi_read("cyc1", BASE + 32'h20, 64'h0, OKAY, 0, c1, lat);
    repeat (8) @(posedge CLK);
    #1;
    axi_read("cyc2", BASE + 32'h20, 64'h0, OKAY, 0, c2, lat);
    check("cycle_diff", c2 - c1, 64'd10);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
